// File: rtl/instr_fetch_if.sv
// Bundle of the instruction fetch stage's three conversations: the
// instruction-memory read port, the valid/ready link to the decoder, and the
// redirect input from branch/jump resolution.
//
// Handshake semantics:
//   mem_req/mem_addr: once mem_req is high, mem_addr stays fixed until the
//     cycle in which mem_ack is high; mem_rdata is taken in that cycle.
//     A request is never withdrawn.
//   instr_valid/instr_ready: the head word moves on a rising edge where both
//     are high; instr/instr_pc stay fixed while instr_valid is high and
//     instr_ready is low.
//   redirect: level-sampled each edge, redirect_pc is taken in that cycle.
interface instr_fetch_if #(
    parameter int WORD_SIZE = 16
);
    logic                 mem_req;
    logic [WORD_SIZE-1:0] mem_addr;
    logic                 mem_ack;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] instr_pc;
    logic                 instr_valid;
    logic                 instr_ready;
    logic                 redirect;
    logic [WORD_SIZE-1:0] redirect_pc;

    // Fetch stage side.
    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid,
        input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );

    // Memory / decoder / branch-unit side.
    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid,
        output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, keeps at most one memory
// read outstanding, buffers returned words in a 2-entry {word, pc} FIFO whose
// head feeds the decoder, and flushes/refetches on redirect.
module instr_fetch #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus,
    output logic [1:0]    dbg_state,
    output logic [1:0]    dbg_count
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [WORD_SIZE-1:0] PC_STEP = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic                 req_q, req_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_SIZE-1:0] pc_inc;
    logic [1:0]           count_q, count_d;
    logic                 issue_ok;
    logic                 push, pop;

    // FIFO slot 0 is always the head; slot 1 is the second-oldest word.
    logic [WORD_SIZE-1:0] word0_q, pc0_q, word1_q, pc1_q;

    assign pop    = (count_q != 2'd0) && bus.instr_ready;
    // Only a live request in REQ delivers data; a redirect in the same cycle
    // drops it together with the rest of the flushed stream.
    assign push   = (state_q == REQ) && bus.mem_ack && !bus.redirect;
    assign pc_inc = fetch_pc_q + PC_STEP;

    // Next-state, request and occupancy logic.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + 2'(push) - 2'(pop);
        end
        // A new request may go out only if its word is guaranteed a slot.
        issue_ok = (count_d <= 2'd1);

        unique case (state_q)
            IDLE: begin
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc;
                    req_d      = 1'b1;
                    addr_d     = bus.redirect_pc;
                    state_d    = REQ;
                end else if (issue_ok) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc;
                    if (bus.mem_ack) begin
                        addr_d = bus.redirect_pc;
                    end else begin
                        // The request cannot be withdrawn; wait it out.
                        state_d = DISCARD;
                    end
                end else if (bus.mem_ack) begin
                    fetch_pc_d = pc_inc;
                    if (issue_ok) begin
                        addr_d = pc_inc;
                    end else begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc;
                end
                if (bus.mem_ack) begin
                    // FIFO is empty here, so the next fetch can go out at once.
                    addr_d  = bus.redirect ? bus.redirect_pc : fetch_pc_q;
                    state_d = REQ;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM, request port, fetch PC and FIFO occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage: shift on pop, write the new word behind the survivors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word0_q <= '0;
            pc0_q   <= '0;
            word1_q <= '0;
            pc1_q   <= '0;
        end else if (!bus.redirect) begin
            if (pop) begin
                if (push && (count_q == 2'd1)) begin
                    word0_q <= bus.mem_rdata;
                    pc0_q   <= addr_q;
                end else begin
                    word0_q <= word1_q;
                    pc0_q   <= pc1_q;
                    if (push) begin
                        word1_q <= bus.mem_rdata;
                        pc1_q   <= addr_q;
                    end
                end
            end else if (push) begin
                if (count_q == 2'd0) begin
                    word0_q <= bus.mem_rdata;
                    pc0_q   <= addr_q;
                end else begin
                    word1_q <= bus.mem_rdata;
                    pc1_q   <= addr_q;
                end
            end
        end
    end

    assign bus.mem_req     = req_q;
    assign bus.mem_addr    = addr_q;
    assign bus.instr       = word0_q;
    assign bus.instr_pc    = pc0_q;
    assign bus.instr_valid = (count_q != 2'd0);

    assign dbg_state = state_q;
    assign dbg_count = count_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a behavioural instruction memory
// (word = address ^ key, configurable or random latency), directed scenarios
// and a long randomized run against a queue-based model of the fetch stream.
`timescale 1ns/1ps
module tb_instr_fetch;
    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if #(.WORD_SIZE(W)) bus ();
    logic [1:0] dbg_state;
    logic [1:0] dbg_count;

    instr_fetch #(.WORD_SIZE(W), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- memory model ----------------
    int           mem_lat  = 0;
    bit           mem_rand = 1'b0;
    bit           mem_spur = 1'b0;
    logic [W-1:0] mem_key  = 16'hA5A5;
    int           wait_cnt = 0;

    // Ack after mem_lat wait cycles (or randomly); optional junk acks while idle.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
            wait_cnt      = 0;
        end else if (bus.mem_req) begin
            if (mem_rand ? ($urandom_range(0, 2) == 0) : (wait_cnt >= mem_lat)) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = bus.mem_addr ^ mem_key;
                wait_cnt      = 0;
            end else begin
                bus.mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            wait_cnt      = 0;
            bus.mem_ack   = mem_spur && ($urandom_range(0, 3) == 0);
            bus.mem_rdata = 16'($urandom);
        end
    end

    // ---------------- driver tasks ----------------
    // Reset with a given memory configuration; returns right after release
    // (at a falling edge), so the next falling edge is cycle 1.
    task automatic do_reset(input logic [W-1:0] key, input int lat, input bit rnd, input bit spur);
        mem_key         = key;
        mem_lat         = lat;
        mem_rand        = rnd;
        mem_spur        = spur;
        rst_n           = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        mem_key = 16'hA5A5; mem_lat = 0; mem_rand = 1'b0; mem_spur = 1'b0;
        rst_n = 1'b0;
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        repeat (3) @(negedge clk);
        #2;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        n_cmp++; if (bus.mem_addr !== 16'h0000) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0000", bus.mem_addr); end
        n_cmp++; if (bus.instr !== 16'h0000) begin n_err++; $display("FAIL reset_instr: got %h want 0000", bus.instr); end
        n_cmp++; if (bus.instr_pc !== 16'h0000) begin n_err++; $display("FAIL reset_instr_pc: got %h want 0000", bus.instr_pc); end
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid); end
        rst_n = 1'b1;
        @(negedge clk); #2;
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0000) begin
            n_err++; $display("FAIL first_request: got req=%b addr=%h want req=1 addr=0000", bus.mem_req, bus.mem_addr);
        end
    endtask

    // Zero-wait memory, consumer always ready: one word per cycle.
    task automatic test_stream();
        logic [W-1:0] e;
        do_reset(16'hA5A5, 0, 1'b0, 1'b0);
        bus.instr_ready = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); #2;
            e = 16'(c - 1);
            n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== e) begin
                n_err++; $display("FAIL stream_req c%0d: got req=%b addr=%h want req=1 addr=%h", c, bus.mem_req, bus.mem_addr, e);
            end
            if (c == 1) begin
                n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_valid c1: got %b want 0", bus.instr_valid); end
            end else begin
                e = 16'(c - 2);
                n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== e || bus.instr !== (e ^ 16'hA5A5)) begin
                    n_err++; $display("FAIL stream_head c%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                                      c, bus.instr_valid, bus.instr_pc, bus.instr, e, e ^ 16'hA5A5);
                end
            end
        end
    endtask

    // Reset pulled between clock edges while the stream is running.
    task automatic test_async_reset();
        @(negedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL async_reset_ctrl: got req=%b valid=%b want 0 0", bus.mem_req, bus.instr_valid);
        end
        n_cmp++; if (bus.mem_addr !== 16'h0000 || bus.instr !== 16'h0000 || bus.instr_pc !== 16'h0000) begin
            n_err++; $display("FAIL async_reset_data: got addr=%h instr=%h pc=%h want 0000", bus.mem_addr, bus.instr, bus.instr_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #2;
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0000 || bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL async_reset_restart: got req=%b addr=%h valid=%b want 1 0000 0", bus.mem_req, bus.mem_addr, bus.instr_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] key;
        logic [W-1:0] e;
        key = 16'($urandom);
        do_reset(key, 0, 1'b0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.instr_ready = 1'b0;
            #2;
            if (c <= 2) begin
                e = 16'(c - 1);
                n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== e) begin
                    n_err++; $display("FAIL bp_req c%0d: got req=%b addr=%h want req=1 addr=%h", c, bus.mem_req, bus.mem_addr, e);
                end
            end else begin
                n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL bp_req_low c%0d: got %b want 0", c, bus.mem_req); end
            end
            if (c >= 2) begin
                n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0000 || bus.instr !== key) begin
                    n_err++; $display("FAIL bp_hold c%0d: got v=%b pc=%h instr=%h want v=1 pc=0000 instr=%h", c, bus.instr_valid, bus.instr_pc, bus.instr, key);
                end
            end
        end
        for (int c = 11; c <= 16; c++) begin
            @(negedge clk);
            bus.instr_ready = 1'b1;
            #2;
            e = 16'(c - 11);
            n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== e || bus.instr !== (e ^ key)) begin
                n_err++; $display("FAIL bp_drain c%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", c, bus.instr_valid, bus.instr_pc, bus.instr, e, e ^ key);
            end
            if (c == 11) begin
                n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL bp_no_comb_req: got %b want 0", bus.mem_req); end
            end
            if (c == 12) begin
                n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0002) begin
                    n_err++; $display("FAIL bp_resume: got req=%b addr=%h want req=1 addr=0002", bus.mem_req, bus.mem_addr);
                end
            end
        end
    endtask

    // 3-cycle memory: address held until ack, word visible the cycle after ack.
    task automatic test_latency();
        logic [W-1:0] key;
        logic         p_req, p_ack;
        logic [W-1:0] p_addr;
        int           acks;
        key = 16'($urandom);
        do_reset(key, 3, 1'b0, 1'b0);
        bus.instr_ready = 1'b1;
        p_req = 1'b0; p_ack = 1'b0; p_addr = '0; acks = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk); #2;
            if (p_req && !p_ack) begin
                n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== p_addr) begin
                    n_err++; $display("FAIL lat_addr_stable c%0d: got req=%b addr=%h want req=1 addr=%h", c, bus.mem_req, bus.mem_addr, p_addr);
                end
            end
            n_cmp++; if (bus.instr_valid !== p_ack) begin
                n_err++; $display("FAIL lat_valid c%0d: got %b want %b", c, bus.instr_valid, p_ack);
            end
            if (p_ack) begin
                n_cmp++; if (bus.instr_pc !== p_addr || bus.instr !== (p_addr ^ key)) begin
                    n_err++; $display("FAIL lat_word c%0d: got pc=%h instr=%h want pc=%h instr=%h", c, bus.instr_pc, bus.instr, p_addr, p_addr ^ key);
                end
            end
            if (bus.mem_req && bus.mem_ack) acks++;
            p_req = bus.mem_req; p_ack = bus.mem_ack; p_addr = bus.mem_addr;
        end
        n_cmp++; if (acks != 10) begin n_err++; $display("FAIL lat_ack_count: got %0d want 10", acks); end
    endtask

    // Redirect while the request to 0x0005 is still waiting for its ack.
    task automatic test_redirect_outstanding();
        logic [W-1:0] key;
        bit           found;
        key = 16'($urandom);
        do_reset(key, 2, 1'b0, 1'b0);
        bus.instr_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk); #2;
            if (bus.mem_req && bus.mem_addr == 16'h0005) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL redir_out_search: got no request to 0005 want one within 60 cycles");
        end else begin
            n_cmp++; if (bus.mem_ack !== 1'b0) begin n_err++; $display("FAIL redir_out_pre_ack: got %b want 0", bus.mem_ack); end
            bus.redirect    = 1'b1;
            bus.redirect_pc = 16'h0040;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                bus.redirect = 1'b0;
                #2;
                if (k <= 2) begin
                    n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0005) begin
                        n_err++; $display("FAIL redir_out_hold k%0d: got req=%b addr=%h want req=1 addr=0005", k, bus.mem_req, bus.mem_addr);
                    end
                end else if (k == 3) begin
                    n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0040) begin
                        n_err++; $display("FAIL redir_out_new_req: got req=%b addr=%h want req=1 addr=0040", bus.mem_req, bus.mem_addr);
                    end
                end
                if (k <= 5) begin
                    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_out_quiet k%0d: got valid=%b pc=%h want valid=0", k, bus.instr_valid, bus.instr_pc); end
                end else begin
                    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0040 || bus.instr !== (16'h0040 ^ key)) begin
                        n_err++; $display("FAIL redir_out_first: got v=%b pc=%h instr=%h want v=1 pc=0040 instr=%h", bus.instr_valid, bus.instr_pc, bus.instr, 16'h0040 ^ key);
                    end
                end
            end
        end
    endtask

    // Redirect coinciding with an ack and a head handshake.
    task automatic test_redirect_handshake();
        logic [W-1:0] key;
        key = 16'($urandom);
        do_reset(key, 0, 1'b0, 1'b0);
        bus.instr_ready = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0003 || bus.mem_ack !== 1'b1 || bus.mem_addr !== 16'h0004) begin
            n_err++; $display("FAIL redir_hs_setup: got v=%b pc=%h ack=%b addr=%h want v=1 pc=0003 ack=1 addr=0004",
                              bus.instr_valid, bus.instr_pc, bus.mem_ack, bus.mem_addr);
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h1230;
        @(negedge clk);
        bus.redirect = 1'b0;
        #2;
        n_cmp++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_hs_flush: got valid=%b pc=%h want valid=0", bus.instr_valid, bus.instr_pc); end
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h1230) begin
            n_err++; $display("FAIL redir_hs_req: got req=%b addr=%h want req=1 addr=1230", bus.mem_req, bus.mem_addr);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #2;
            n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'(16'h1230 + k) || bus.instr !== (16'(16'h1230 + k) ^ key)) begin
                n_err++; $display("FAIL redir_hs_next k%0d: got v=%b pc=%h instr=%h want v=1 pc=%h", k, bus.instr_valid, bus.instr_pc, bus.instr, 16'(16'h1230 + k));
            end
        end
    endtask

    // Fetch addresses wrap from FFFF to 0000.
    task automatic test_wrap();
        logic [W-1:0] key;
        logic [W-1:0] got_q[$];
        logic [W-1:0] exp_q[$];
        key = 16'($urandom);
        do_reset(key, 0, 1'b0, 1'b0);
        bus.instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFE;
        exp_q = '{16'hFFFE, 16'hFFFF, 16'h0000};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.redirect = 1'b0;
            #2;
            if (bus.instr_valid && bus.instr_ready) begin
                got_q.push_back(bus.instr_pc);
                n_cmp++; if (bus.instr !== (bus.instr_pc ^ key)) begin
                    n_err++; $display("FAIL wrap_word: got %h want %h", bus.instr, bus.instr_pc ^ key);
                end
            end
        end
        n_cmp++;
        if (got_q.size() < 3) begin
            n_err++; $display("FAIL wrap_count: got %0d words want at least 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_pc %0d: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    // Random latency, ready, redirects and idle junk acks against a
    // transaction-level model: expected FIFO contents and next fetch address.
    task automatic test_random();
        logic [2*W-1:0] exp_q[$];
        logic [W-1:0]   m_fetch;
        logic [W-1:0]   key;
        bit             m_squash;
        logic           p_req, p_ack;
        logic [W-1:0]   p_addr;
        key = 16'($urandom);
        do_reset(key, 0, 1'b1, 1'b1);
        exp_q.delete();
        m_fetch = 16'h0000; m_squash = 1'b0;
        p_req = 1'b0; p_ack = 1'b0; p_addr = '0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.redirect    = ($urandom_range(0, 24) == 0);
            bus.redirect_pc = ($urandom_range(0, 1) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
            #2;
            n_cmp++; if (bus.instr_valid !== (exp_q.size() != 0)) begin
                n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.instr_valid, exp_q.size() != 0);
            end
            if (bus.instr_valid && exp_q.size() != 0) begin
                n_cmp++; if ({bus.instr_pc, bus.instr} !== exp_q[0]) begin
                    n_err++; $display("FAIL rnd_head c%0d: got pc=%h instr=%h want pc=%h instr=%h", c, bus.instr_pc, bus.instr, exp_q[0][2*W-1:W], exp_q[0][W-1:0]);
                end
            end
            if (p_req && !p_ack) begin
                n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== p_addr) begin
                    n_err++; $display("FAIL rnd_hold c%0d: got req=%b addr=%h want req=1 addr=%h", c, bus.mem_req, bus.mem_addr, p_addr);
                end
            end else if (bus.mem_req) begin
                n_cmp++; if (bus.mem_addr !== m_fetch) begin
                    n_err++; $display("FAIL rnd_req_addr c%0d: got %h want %h", c, bus.mem_addr, m_fetch);
                end
                n_cmp++; if (exp_q.size() > 1) begin
                    n_err++; $display("FAIL rnd_issue_rule c%0d: got request with %0d buffered want at most 1", c, exp_q.size());
                end
            end
            if (!bus.mem_req) begin
                n_cmp++; if (exp_q.size() != 2) begin
                    n_err++; $display("FAIL rnd_stall c%0d: got idle with %0d buffered want 2", c, exp_q.size());
                end
            end
            // Advance the model across this clock edge.
            if (bus.instr_valid && bus.instr_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (bus.mem_req && bus.mem_ack) begin
                if (!m_squash && !bus.redirect) begin
                    exp_q.push_back({bus.mem_addr, bus.mem_addr ^ key});
                    m_fetch = m_fetch + 16'd1;
                end
                m_squash = 1'b0;
            end
            if (bus.redirect) begin
                exp_q.delete();
                m_fetch = bus.redirect_pc;
                if (bus.mem_req && !bus.mem_ack) m_squash = 1'b1;
            end
            p_req = bus.mem_req; p_ack = bus.mem_ack; p_addr = bus.mem_addr;
        end
        bus.redirect = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        test_reset();
        test_stream();
        test_async_reset();
        test_backpressure();
        test_latency();
        test_redirect_outstanding();
        test_redirect_handshake();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test want finish before 1 ms");
        $fatal(1, "watchdog expired");
    end
endmodule
